// File: rtl/btb_pkg.sv
// Shared constants and clear-sequencer state type for the BTB set array.
// Defaults below match the fetch-stage BTB (8 sets x 2 lanes x 64 bits).
package btb_pkg;

   localparam int BTB_SETS   = 8;
   localparam int BTB_LANES  = 2;
   localparam int BTB_LANE_W = 64;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } btb_clr_state_t;

endpackage

// File: rtl/btb_clear_fsm.sv
// Invalidate sequencer: walks every set after reset or flush, writing zero,
// then raises ready. Also drives the clear write index and strobe.
//
// state | meaning
// ------+----------------------------------------------------------
// CLEAR | zeroing set r_cnt on each edge; ready=0, user access blocked
// IDLE  | array valid; ready=1; flush restarts the sweep
module btb_clear_fsm
   import btb_pkg::*;
#(
   parameter int SETS  = BTB_SETS,
   parameter int IDX_W = $clog2(SETS)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   output logic             o_ready,
   output logic             o_clr_we,
   output logic [IDX_W-1:0] o_clr_index
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

   btb_clr_state_t   r_state;
   logic [IDX_W-1:0] r_cnt;
   logic             r_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= CLEAR;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               if (i_flush) begin
                  r_cnt <= '0;
               end else if (r_cnt == LAST_IDX) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (i_flush) begin
                  r_state <= CLEAR;
                  r_cnt   <= '0;
                  r_ready <= 1'b0;
               end
            end
            default: begin
               r_state <= CLEAR;
               r_cnt   <= '0;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready     = r_ready;
   assign o_clr_we    = (r_state == CLEAR);
   assign o_clr_index = r_cnt;

endmodule

// File: rtl/btb_set_array.sv
// BTB set storage with per-lane write masks, lane-level write-to-read bypass
// and hardware invalidate. BTB_READ_REG_EN adds a 1-cycle registered read.
module btb_set_array
   import btb_pkg::*;
#(
   parameter  int SETS   = BTB_SETS,
   parameter  int LANES  = BTB_LANES,
   parameter  int LANE_W = BTB_LANE_W,
   localparam int IDX_W  = $clog2(SETS),
   localparam int SET_W  = LANES * LANE_W
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_flush,
   output logic               o_ready,
   input  logic [IDX_W-1:0]   i_read_index,
   output logic [SET_W-1:0]   o_read_set,
   input  logic [IDX_W-1:0]   i_write_index,
   input  logic [SET_W-1:0]   i_write_set,
   input  logic               i_write_enable,
   input  logic [LANES-1:0]   i_write_lane_en
);

   logic [SET_W-1:0] r_mem [SETS];

   logic             w_ready;
   logic             w_clr_we;
   logic [IDX_W-1:0] w_clr_index;
   logic [LANES-1:0] w_lane_we;
   logic [SET_W-1:0] w_read_set;

   btb_clear_fsm #(
      .SETS  (SETS),
      .IDX_W (IDX_W)
   ) u_clear_fsm (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_flush     (i_flush),
      .o_ready     (w_ready),
      .o_clr_we    (w_clr_we),
      .o_clr_index (w_clr_index)
   );

   assign o_ready   = w_ready;
   assign w_lane_we = (w_ready && i_write_enable) ? i_write_lane_en : '0;

   // The array itself is never reset; the clear sweep zeroes it instead.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (w_clr_we) begin
            r_mem[w_clr_index] <= '0;
         end else begin
            for (int l = 0; l < LANES; l++) begin
               if (w_lane_we[l]) begin
                  r_mem[i_write_index][l*LANE_W +: LANE_W] <= i_write_set[l*LANE_W +: LANE_W];
               end
            end
         end
      end
   end

   always_comb begin
      w_read_set = '0;
      if (w_ready) begin
         w_read_set = r_mem[i_read_index];
         if (i_read_index == i_write_index) begin
            for (int l = 0; l < LANES; l++) begin
               if (w_lane_we[l]) begin
                  w_read_set[l*LANE_W +: LANE_W] = i_write_set[l*LANE_W +: LANE_W];
               end
            end
         end
      end
   end

`ifdef BTB_READ_REG_EN
   logic [SET_W-1:0] r_read_set;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_read_set <= '0;
      end else begin
         r_read_set <= w_read_set;
      end
   end

   assign o_read_set = r_read_set;
`else
   assign o_read_set = w_read_set;
`endif

endmodule
